trap_ctrl: RTL and testbench



---
 rtl/trap_ctrl_pkg.sv | 24 ++
 rtl/trap_prio_enc.sv | 39 +++
 rtl/trap_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_trap_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_ctrl_pkg.sv
// trap_ctrl_pkg
//   Shared definitions for the machine-mode trap sequencer: FSM state
//   encoding, interrupt cause codes and the synchronous exception codes
//   the EX stage reports.
package trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SAVE = 2'd1,
    ST_JUMP = 2'd2,
    ST_RET  = 2'd3
  } trap_state_e;

  // Interrupt cause codes (mcause low bits when mcause[XLEN-1] = 1)
  localparam logic [3:0] CAUSE_MEI = 4'd11;
  localparam logic [3:0] CAUSE_MSI = 4'd3;
  localparam logic [3:0] CAUSE_MTI = 4'd7;

  // Synchronous exception codes
  localparam logic [3:0] EXC_ILLEGAL = 4'd2;
  localparam logic [3:0] EXC_ECALL   = 4'd11;
  localparam logic [3:0] EXC_BREAK   = 4'd3;

endpackage

// File: rtl/trap_prio_enc.sv
// trap_prio_enc
//   Masks the level interrupt requests with their per-source enables and
//   the global enable, then picks one cause with fixed priority
//   external > software > timer.
// Ports:
//   ext/sft/tmr_irq_i  level requests
//   meie/msie/mtie_i   per-source enables
//   glb_irq_i          mstatus.MIE
//   irq_pend_o         at least one enabled interrupt is pending
//   irq_cause_o        cause code of the winning source
module trap_prio_enc
  import trap_ctrl_pkg::*;
(
  input  logic       ext_irq_i,
  input  logic       sft_irq_i,
  input  logic       tmr_irq_i,
  input  logic       meie_i,
  input  logic       msie_i,
  input  logic       mtie_i,
  input  logic       glb_irq_i,
  output logic       irq_pend_o,
  output logic [3:0] irq_cause_o
);

  logic ext_m, sft_m, tmr_m;

  assign ext_m = ext_irq_i & meie_i;
  assign sft_m = sft_irq_i & msie_i;
  assign tmr_m = tmr_irq_i & mtie_i;

  assign irq_pend_o = glb_irq_i & (ext_m | sft_m | tmr_m);

  always_comb begin
    irq_cause_o = CAUSE_MTI;
    if (ext_m)      irq_cause_o = CAUSE_MEI;
    else if (sft_m) irq_cause_o = CAUSE_MSI;
  end

endmodule

// File: rtl/trap_ctrl.sv
// trap_ctrl
//   Machine-mode trap sequencer. Accepts an exception, mret or pending
//   interrupt for the instruction in EX, stalls and flushes the front of the
//   pipeline, pulses the CSR update strobe and finally redirects the PC.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   *_irq_i, m*ie_i, glb_irq_i interrupt requests and enables
//   ex_valid_i, ex_pc_i        EX stage occupancy and PC
//   exp_req_i/code_i/tval_i    synchronous exception from EX
//   mret_i                     EX instruction is mret
//   irq_pc_i, mepc_i           handler entry / return address from CSR
//   stall_o, flush_o           pipeline control
//   irq_src_o, exp_src_o       one-cycle trap-entry pulses to CSR
//   mret_ena_o                 one-cycle return pulse to CSR
//   trap_pc_o, mcause_o,
//   mtval_o                    values for the CSR trap registers
//   jump_en_o, jump_pc_o       PC redirect
//   busy_o                     sequence in progress
//
// state | meaning
// IDLE  | waiting for an event on a valid EX instruction
// SAVE  | pulse irq/exp entry to CSR with latched mepc/mcause/mtval
// RET   | pulse mret to CSR, capture mepc as return target
// JUMP  | redirect PC to handler or return target
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int CAUSE_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ext_irq_i,
  input  logic               sft_irq_i,
  input  logic               tmr_irq_i,
  input  logic               meie_i,
  input  logic               msie_i,
  input  logic               mtie_i,
  input  logic               glb_irq_i,
  input  logic               ex_valid_i,
  input  logic [XLEN-1:0]    ex_pc_i,
  input  logic               exp_req_i,
  input  logic [CAUSE_W-1:0] exp_code_i,
  input  logic [XLEN-1:0]    exp_tval_i,
  input  logic               mret_i,
  input  logic [XLEN-1:0]    irq_pc_i,
  input  logic [XLEN-1:0]    mepc_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic               irq_src_o,
  output logic               exp_src_o,
  output logic               mret_ena_o,
  output logic [XLEN-1:0]    trap_pc_o,
  output logic [XLEN-1:0]    mcause_o,
  output logic [XLEN-1:0]    mtval_o,
  output logic               jump_en_o,
  output logic [XLEN-1:0]    jump_pc_o,
  output logic               busy_o
);

  trap_state_e state_q, state_d;

  logic            irq_pend;
  logic [3:0]      irq_cause;

  logic            take_exp, take_mret, take_irq, accept;

  logic [XLEN-1:0] trap_pc_q, trap_pc_d;
  logic [XLEN-1:0] mcause_q,  mcause_d;
  logic [XLEN-1:0] mtval_q,   mtval_d;
  logic [XLEN-1:0] ret_pc_q,  ret_pc_d;
  logic            is_irq_q,  is_irq_d;
  logic            is_ret_q,  is_ret_d;

  trap_prio_enc u_prio (
    .ext_irq_i   (ext_irq_i),
    .sft_irq_i   (sft_irq_i),
    .tmr_irq_i   (tmr_irq_i),
    .meie_i      (meie_i),
    .msie_i      (msie_i),
    .mtie_i      (mtie_i),
    .glb_irq_i   (glb_irq_i),
    .irq_pend_o  (irq_pend),
    .irq_cause_o (irq_cause)
  );

  // Event priority: exception > mret > interrupt, only on a valid EX slot
  assign take_exp  = (state_q == ST_IDLE) & ex_valid_i & exp_req_i;
  assign take_mret = (state_q == ST_IDLE) & ex_valid_i & ~exp_req_i & mret_i;
  assign take_irq  = (state_q == ST_IDLE) & ex_valid_i & ~exp_req_i & ~mret_i & irq_pend;
  assign accept    = take_exp | take_mret | take_irq;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_exp || take_irq) state_d = ST_SAVE;
        else if (take_mret)       state_d = ST_RET;
      end
      ST_SAVE: state_d = ST_JUMP;
      ST_RET:  state_d = ST_JUMP;
      ST_JUMP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched trap fields
  always_comb begin
    trap_pc_d = trap_pc_q;
    mcause_d  = mcause_q;
    mtval_d   = mtval_q;
    ret_pc_d  = ret_pc_q;
    is_irq_d  = is_irq_q;
    is_ret_d  = is_ret_q;
    if (take_exp) begin
      trap_pc_d = ex_pc_i;
      mcause_d  = XLEN'(exp_code_i);
      mtval_d   = exp_tval_i;
      is_irq_d  = 1'b0;
      is_ret_d  = 1'b0;
    end else if (take_irq) begin
      // Interrupted instruction is squashed, so mepc points back at it
      trap_pc_d = ex_pc_i;
      mcause_d  = {1'b1, {(XLEN-5){1'b0}}, irq_cause};
      mtval_d   = '0;
      is_irq_d  = 1'b1;
      is_ret_d  = 1'b0;
    end else if (take_mret) begin
      is_ret_d  = 1'b1;
    end
    if (state_q == ST_RET) ret_pc_d = mepc_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_pc_q <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
      ret_pc_q  <= '0;
      is_irq_q  <= 1'b0;
      is_ret_q  <= 1'b0;
    end else begin
      trap_pc_q <= trap_pc_d;
      mcause_q  <= mcause_d;
      mtval_q   <= mtval_d;
      ret_pc_q  <= ret_pc_d;
      is_irq_q  <= is_irq_d;
      is_ret_q  <= is_ret_d;
    end
  end

  // Output logic
  always_comb begin
    stall_o    = 1'b0;
    flush_o    = 1'b0;
    irq_src_o  = 1'b0;
    exp_src_o  = 1'b0;
    mret_ena_o = 1'b0;
    jump_en_o  = 1'b0;
    jump_pc_o  = '0;
    busy_o     = (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        stall_o = accept;
        flush_o = accept;
      end
      ST_SAVE: begin
        stall_o   = 1'b1;
        flush_o   = 1'b1;
        irq_src_o = is_irq_q;
        exp_src_o = ~is_irq_q;
      end
      ST_RET: begin
        stall_o    = 1'b1;
        flush_o    = 1'b1;
        mret_ena_o = 1'b1;
      end
      ST_JUMP: begin
        stall_o   = 1'b1;
        flush_o   = 1'b1;
        jump_en_o = 1'b1;
        // irq_pc_i sampled now so a vectored mtvec sees the new mcause
        jump_pc_o = is_ret_q ? ret_pc_q : irq_pc_i;
      end
      default: ;
    endcase
  end

  assign trap_pc_o = trap_pc_q;
  assign mcause_o  = mcause_q;
  assign mtval_o   = mtval_q;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;
  import trap_ctrl_pkg::*;

  localparam int XLEN = 64;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ext_irq_i, sft_irq_i, tmr_irq_i;
  logic            meie_i, msie_i, mtie_i, glb_irq_i;
  logic            ex_valid_i;
  logic [XLEN-1:0] ex_pc_i;
  logic            exp_req_i;
  logic [CW-1:0]   exp_code_i;
  logic [XLEN-1:0] exp_tval_i;
  logic            mret_i;
  logic [XLEN-1:0] irq_pc_i, mepc_i;
  logic            stall_o, flush_o, irq_src_o, exp_src_o, mret_ena_o;
  logic [XLEN-1:0] trap_pc_o, mcause_o, mtval_o;
  logic            jump_en_o;
  logic [XLEN-1:0] jump_pc_o;
  logic            busy_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  trap_ctrl #(.XLEN(XLEN), .CAUSE_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ext_irq_i  (ext_irq_i),
    .sft_irq_i  (sft_irq_i),
    .tmr_irq_i  (tmr_irq_i),
    .meie_i     (meie_i),
    .msie_i     (msie_i),
    .mtie_i     (mtie_i),
    .glb_irq_i  (glb_irq_i),
    .ex_valid_i (ex_valid_i),
    .ex_pc_i    (ex_pc_i),
    .exp_req_i  (exp_req_i),
    .exp_code_i (exp_code_i),
    .exp_tval_i (exp_tval_i),
    .mret_i     (mret_i),
    .irq_pc_i   (irq_pc_i),
    .mepc_i     (mepc_i),
    .stall_o    (stall_o),
    .flush_o    (flush_o),
    .irq_src_o  (irq_src_o),
    .exp_src_o  (exp_src_o),
    .mret_ena_o (mret_ena_o),
    .trap_pc_o  (trap_pc_o),
    .mcause_o   (mcause_o),
    .mtval_o    (mtval_o),
    .jump_en_o  (jump_en_o),
    .jump_pc_o  (jump_pc_o),
    .busy_o     (busy_o)
  );

  task automatic clear_inputs();
    ext_irq_i = 0; sft_irq_i = 0; tmr_irq_i = 0;
    meie_i = 0; msie_i = 0; mtie_i = 0; glb_irq_i = 0;
    ex_valid_i = 0; ex_pc_i = '0; exp_req_i = 0; exp_code_i = '0;
    exp_tval_i = '0; mret_i = 0; irq_pc_i = 64'h8000_0000; mepc_i = '0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    irq_pc_i = '0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      total++;
      if ({stall_o, flush_o, irq_src_o, exp_src_o, mret_ena_o, jump_en_o, busy_o,
           trap_pc_o, mcause_o, mtval_o, jump_pc_o} !== '0) begin
        bad++;
        $display("FAIL reset_idle cycle %0d: stall=%b flush=%b irq=%b exp=%b mret=%b jmp=%b busy=%b tpc=%h mc=%h tv=%h jpc=%h want all 0",
                 i, stall_o, flush_o, irq_src_o, exp_src_o, mret_ena_o, jump_en_o, busy_o,
                 trap_pc_o, mcause_o, mtval_o, jump_pc_o);
      end
    end
  endtask

  task automatic test_timer_irq();
    @(negedge clk);
    clear_inputs();
    tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; ex_valid_i = 1; ex_pc_i = 64'h8000_0100;
    #1;
    total++;
    if ({stall_o, flush_o, busy_o} !== 3'b110) begin
      bad++; $display("FAIL tmr_accept stall/flush/busy got=%b want=110", {stall_o, flush_o, busy_o});
    end
    @(negedge clk);
    ex_valid_i = 0; tmr_irq_i = 0; glb_irq_i = 0;
    #1;
    total++;
    if ({irq_src_o, exp_src_o, mret_ena_o, stall_o, flush_o} !== 5'b10011) begin
      bad++; $display("FAIL tmr_save pulses got=%b want=10011", {irq_src_o, exp_src_o, mret_ena_o, stall_o, flush_o});
    end
    total++;
    if (mcause_o !== 64'h8000_0000_0000_0007) begin
      bad++; $display("FAIL tmr_mcause got=%h want=8000000000000007", mcause_o);
    end
    total++;
    if (trap_pc_o !== 64'h8000_0100 || mtval_o !== 64'h0) begin
      bad++; $display("FAIL tmr_tpc_tval got=%h/%h want=80000100/0", trap_pc_o, mtval_o);
    end
    @(negedge clk); #1;
    total++;
    if (jump_en_o !== 1'b1 || jump_pc_o !== 64'h8000_0000 || irq_src_o !== 1'b0) begin
      bad++; $display("FAIL tmr_jump en=%b pc=%h irq=%b want 1/80000000/0", jump_en_o, jump_pc_o, irq_src_o);
    end
    @(negedge clk); #1;
    total++;
    if ({stall_o, busy_o, jump_en_o} !== 3'b000) begin
      bad++; $display("FAIL tmr_done stall/busy/jump got=%b want=000", {stall_o, busy_o, jump_en_o});
    end
  endtask

  task automatic test_exception_vs_irq();
    @(negedge clk);
    clear_inputs();
    ext_irq_i = 1; meie_i = 1; glb_irq_i = 1;
    exp_req_i = 1; exp_code_i = EXC_ILLEGAL; exp_tval_i = 64'hDEAD;
    ex_valid_i = 1; ex_pc_i = 64'h8000_0200;
    #1;
    total++;
    if (stall_o !== 1'b1) begin
      bad++; $display("FAIL exc_accept stall got=%b want=1", stall_o);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if ({exp_src_o, irq_src_o} !== 2'b10) begin
      bad++; $display("FAIL exc_pulse exp/irq got=%b want=10", {exp_src_o, irq_src_o});
    end
    total++;
    if (mcause_o !== 64'd2 || mtval_o !== 64'hDEAD || trap_pc_o !== 64'h8000_0200) begin
      bad++; $display("FAIL exc_fields mc=%h tv=%h tpc=%h want 2/dead/80000200", mcause_o, mtval_o, trap_pc_o);
    end
    @(negedge clk); #1;
    total++;
    if (jump_en_o !== 1'b1 || jump_pc_o !== 64'h8000_0000 || irq_src_o !== 1'b0) begin
      bad++; $display("FAIL exc_jump en=%b pc=%h irq=%b want 1/80000000/0", jump_en_o, jump_pc_o, irq_src_o);
    end
    @(negedge clk); #1;
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL exc_done busy got=%b want=0", busy_o);
    end
  endtask

  task automatic test_mret();
    @(negedge clk);
    clear_inputs();
    mret_i = 1; ex_valid_i = 1; mepc_i = 64'h8000_0104;
    #1;
    total++;
    if ({stall_o, flush_o} !== 2'b11) begin
      bad++; $display("FAIL mret_accept stall/flush got=%b want=11", {stall_o, flush_o});
    end
    @(negedge clk);
    mret_i = 0; ex_valid_i = 0;
    #1;
    total++;
    if ({mret_ena_o, irq_src_o, exp_src_o} !== 3'b100) begin
      bad++; $display("FAIL mret_pulse ret/irq/exp got=%b want=100", {mret_ena_o, irq_src_o, exp_src_o});
    end
    total++;
    if (trap_pc_o !== 64'h8000_0200) begin
      bad++; $display("FAIL mret_hold_tpc got=%h want=80000200", trap_pc_o);
    end
    @(negedge clk);
    mepc_i = 64'h1234_5678;
    #1;
    total++;
    if (jump_en_o !== 1'b1 || jump_pc_o !== 64'h8000_0104 || mret_ena_o !== 1'b0) begin
      bad++; $display("FAIL mret_jump en=%b pc=%h ret=%b want 1/80000104/0", jump_en_o, jump_pc_o, mret_ena_o);
    end
    @(negedge clk); #1;
    total++;
    if ({stall_o, busy_o} !== 2'b00) begin
      bad++; $display("FAIL mret_done stall/busy got=%b want=00", {stall_o, busy_o});
    end
  endtask

  task automatic test_priority();
    logic [63:0] want [3];
    want[0] = 64'h8000_0000_0000_000B;
    want[1] = 64'h8000_0000_0000_0003;
    want[2] = 64'h8000_0000_0000_0007;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      clear_inputs();
      ext_irq_i = 1; sft_irq_i = 1; tmr_irq_i = 1; glb_irq_i = 1;
      meie_i = (k == 0); msie_i = (k <= 1); mtie_i = 1;
      ex_valid_i = 1; ex_pc_i = 64'h8000_0400 + 64'(k * 4);
      @(negedge clk);
      ex_valid_i = 0;
      #1;
      total++;
      if (irq_src_o !== 1'b1 || mcause_o !== want[k]) begin
        bad++; $display("FAIL prio_%0d irq=%b mcause=%h want 1/%h", k, irq_src_o, mcause_o, want[k]);
      end
      @(negedge clk);
      @(negedge clk); #1;
      total++;
      if (busy_o !== 1'b0) begin
        bad++; $display("FAIL prio_%0d_done busy got=%b want=0", k, busy_o);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    clear_inputs();
    tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; ex_valid_i = 1; ex_pc_i = 64'h8000_0500;
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (irq_src_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_in_save irq got=%b want=1", irq_src_o);
    end
    rst_n = 0;
    #1;
    total++;
    if ({busy_o, irq_src_o, stall_o} !== 3'b000) begin
      bad++; $display("FAIL rstmid_asserted busy/irq/stall got=%b want=000", {busy_o, irq_src_o, stall_o});
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if ({jump_en_o, irq_src_o, exp_src_o, mret_ena_o, busy_o} !== 5'b0 || trap_pc_o !== 64'h0) begin
        bad++; $display("FAIL rstmid_after %0d jmp/irq/exp/ret/busy=%b tpc=%h want 0/0",
                        i, {jump_en_o, irq_src_o, exp_src_o, mret_ena_o, busy_o}, trap_pc_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    clear_inputs();
    tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; ex_valid_i = 1; ex_pc_i = 64'h8000_0600;
    @(negedge clk); #1;
    total++;
    if (irq_src_o !== 1'b1) begin
      bad++; $display("FAIL b2b_save irq got=%b want=1", irq_src_o);
    end
    @(negedge clk); #1;
    total++;
    if (jump_en_o !== 1'b1 || irq_src_o !== 1'b0 || busy_o !== 1'b1) begin
      bad++; $display("FAIL b2b_jump en=%b irq=%b busy=%b want 1/0/1", jump_en_o, irq_src_o, busy_o);
    end
    @(negedge clk); #1;
    total++;
    if ({busy_o, stall_o, jump_en_o} !== 3'b010) begin
      bad++; $display("FAIL b2b_reaccept busy/stall/jmp got=%b want=010", {busy_o, stall_o, jump_en_o});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (irq_src_o !== 1'b1) begin
      bad++; $display("FAIL b2b_second_save irq got=%b want=1", irq_src_o);
    end
    @(negedge clk);
    @(negedge clk); #1;
    total++;
    if (busy_o !== 1'b0) begin
      bad++; $display("FAIL b2b_done busy got=%b want=0", busy_o);
    end
  endtask

  task automatic test_mret_vs_irq();
    @(negedge clk);
    clear_inputs();
    tmr_irq_i = 1; mtie_i = 1; glb_irq_i = 1; mret_i = 1; ex_valid_i = 1;
    ex_pc_i = 64'h8000_0700; mepc_i = 64'h8000_0300;
    @(negedge clk);
    mret_i = 0;
    #1;
    total++;
    if ({mret_ena_o, irq_src_o, exp_src_o} !== 3'b100) begin
      bad++; $display("FAIL mri_pulse ret/irq/exp got=%b want=100", {mret_ena_o, irq_src_o, exp_src_o});
    end
    @(negedge clk); #1;
    total++;
    if (jump_en_o !== 1'b1 || jump_pc_o !== 64'h8000_0300) begin
      bad++; $display("FAIL mri_jump en=%b pc=%h want 1/80000300", jump_en_o, jump_pc_o);
    end
    @(negedge clk); #1;
    total++;
    if ({busy_o, stall_o} !== 2'b01) begin
      bad++; $display("FAIL mri_irq_accept busy/stall got=%b want=01", {busy_o, stall_o});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    total++;
    if (irq_src_o !== 1'b1 || mcause_o !== 64'h8000_0000_0000_0007 || trap_pc_o !== 64'h8000_0700) begin
      bad++; $display("FAIL mri_irq_save irq=%b mc=%h tpc=%h want 1/8000000000000007/80000700",
                      irq_src_o, mcause_o, trap_pc_o);
    end
    @(negedge clk); #1;
    total++;
    if (jump_pc_o !== 64'h8000_0000) begin
      bad++; $display("FAIL mri_irq_jump pc=%h want 80000000", jump_pc_o);
    end
    @(negedge clk);
  endtask

  task automatic test_bubble();
    @(negedge clk);
    clear_inputs();
    ext_irq_i = 1; meie_i = 1; glb_irq_i = 1; ex_valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if ({stall_o, busy_o, irq_src_o} !== 3'b000) begin
        bad++; $display("FAIL bubble %0d stall/busy/irq got=%b want=000", i, {stall_o, busy_o, irq_src_o});
      end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_timer_irq();
    test_exception_vs_irq();
    test_mret();
    test_priority();
    test_reset_mid();
    test_back_to_back();
    test_mret_vs_irq();
    test_bubble();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
